// File: rtl/mac_seq32.sv
// Sequential 32x32 multiplier (RISC-V MUL/MULH/MULHSU/MULHU) on an external 16x16 unsigned DSP.
// Optional feature: define MAC_SEQ_ZERO_SKIP_EN to short-circuit zero operands straight to DONE.
module mac_seq32 #(
  parameter int unsigned DSP_LAT = 1
) (
  input  logic        clock,
  input  logic        IRSTTOP,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_funct,
  output logic [15:0] dsp_a,
  output logic [15:0] dsp_b,
  output logic        dsp_ce,
  input  logic [31:0] dsp_o,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] FunctMul    = 2'b00;
  localparam logic [1:0] FunctMulh   = 2'b01;
  localparam logic [1:0] FunctMulhsu = 2'b10;
  localparam logic [2:0] LatW        = 3'(DSP_LAT);

  state_t      state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  funct_q;
  logic [63:0] acc;
  logic [2:0]  cyc;

  logic        zero_hit;
  logic [2:0]  cap_k;
  logic        cap_en;
  logic [63:0] prod_sh;
  logic [63:0] sub_a;
  logic [63:0] sub_b;
  logic [63:0] acc_fix;
  logic [1:0]  next_k;

`ifdef MAC_SEQ_ZERO_SKIP_EN
  assign zero_hit = (req_a == 32'd0) || (req_b == 32'd0);
`else
  assign zero_hit = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Pair k leaves the DSP DSP_LAT cycles after it was issued; cyc < LatW wraps cap_k to >= 4.
  assign cap_k  = cyc - LatW;
  assign cap_en = ((state == ISSUE) || (state == DRAIN)) && !cap_k[2];
  assign next_k = cyc[1:0] + 2'd1;

  always_comb begin
    prod_sh = 64'd0;
    unique case (cap_k[1:0])
      2'd0:    prod_sh = {32'd0, dsp_o};
      2'd1:    prod_sh = {16'd0, dsp_o, 16'd0};
      2'd2:    prod_sh = {16'd0, dsp_o, 16'd0};
      default: prod_sh = {dsp_o, 32'd0};
    endcase
  end

  // Signed correction of the unsigned product: subtract the other operand shifted up by 32
  // for every operand that is treated as signed and negative.
  always_comb begin
    sub_a = 64'd0;
    sub_b = 64'd0;
    if (((funct_q == FunctMulh) || (funct_q == FunctMulhsu)) && a_q[31]) begin
      sub_a = {b_q, 32'd0};
    end
    if ((funct_q == FunctMulh) && b_q[31]) begin
      sub_b = {a_q, 32'd0};
    end
    acc_fix = acc - sub_a - sub_b;
  end

  always_ff @(posedge clock or posedge IRSTTOP) begin
    if (IRSTTOP) begin
      state     <= IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      funct_q   <= 2'd0;
      acc       <= 64'd0;
      cyc       <= 3'd0;
      dsp_a     <= 16'd0;
      dsp_b     <= 16'd0;
      dsp_ce    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            funct_q <= req_funct;
            acc     <= 64'd0;
            cyc     <= 3'd0;
            if (zero_hit) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_data  <= 32'd0;
            end else begin
              state  <= ISSUE;
              dsp_a  <= req_a[15:0];
              dsp_b  <= req_b[15:0];
              dsp_ce <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cyc <= cyc + 3'd1;
          if (cap_en) begin
            acc <= acc + prod_sh;
          end
          if (cyc[1:0] != 2'd3) begin
            dsp_a <= next_k[1] ? a_q[31:16] : a_q[15:0];
            dsp_b <= next_k[0] ? b_q[31:16] : b_q[15:0];
          end else if (DSP_LAT == 0) begin
            state  <= FIX;
            dsp_ce <= 1'b0;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          cyc <= cyc + 3'd1;
          if (cap_en) begin
            acc <= acc + prod_sh;
          end
          if (cyc == (LatW + 3'd3)) begin
            state  <= FIX;
            dsp_ce <= 1'b0;
          end
        end
        FIX: begin
          acc       <= acc_fix;
          rsp_data  <= (funct_q == FunctMul) ? acc_fix[31:0] : acc_fix[63:32];
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq32.sv
// Directed self-checking bench for mac_seq32 with a behavioural SB_MAC16 pipeline model.
module tb_mac_seq32;

  localparam int unsigned LAT = 1;

  logic        clock;
  logic        IRSTTOP;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_funct;
  logic [15:0] dsp_a;
  logic [15:0] dsp_b;
  logic        dsp_ce;
  logic [31:0] dsp_o;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mac_seq32 #(.DSP_LAT(LAT)) dut (
    .clock     (clock),
    .IRSTTOP   (IRSTTOP),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_funct (req_funct),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_ce    (dsp_ce),
    .dsp_o     (dsp_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DSP model: unsigned 16x16, LAT clock-enabled register stages
  logic [31:0] prod;
  logic [31:0] pipe [0:2];
  assign prod = 32'(dsp_a) * 32'(dsp_b);

  always_ff @(posedge clock) begin
    if (dsp_ce) begin
      pipe[0] <= prod;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  always_comb begin
    dsp_o = prod;
    case (LAT)
      1:       dsp_o = pipe[0];
      2:       dsp_o = pipe[1];
      3:       dsp_o = pipe[2];
      default: dsp_o = prod;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction: accept, wait (bounded) for rsp_valid, optional stall, handshake.
  task automatic do_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int exp_ce, input int stall);
    int n;
    int ce_cnt;
    logic [31:0] held;
    @(negedge clock);
    check({tag, "_req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_funct = f;
    rsp_ready = 1'b0;
    @(posedge clock);
    #1;
    // Keep junk on the request port; it must be ignored while busy.
    req_a     = ~a;
    req_b     = ~b;
    req_funct = ~f;
    n = 0;
    ce_cnt = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (dsp_ce) ce_cnt++;
      if (rsp_valid) break;
    end
    req_valid = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_ce_cycles"}, 32'(ce_cnt), 32'(exp_ce));
    held = rsp_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      check({tag, "_stall_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_stall_data"}, rsp_data, held);
      check({tag, "_stall_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    @(negedge clock);
    check({tag, "_post_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_post_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int full_lat;
    int full_ce;
    int seen;
    full_lat  = 6 + LAT;
    full_ce   = 4 + LAT;
    IRSTTOP   = 1'b1;
    req_valid = 1'b0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    req_funct = 2'd0;
    rsp_ready = 1'b0;
    #3;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_dsp_ce", {31'd0, dsp_ce}, 32'd0);
    check("rst_dsp_ab", {dsp_a, dsp_b}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clock);
    @(negedge clock);
    IRSTTOP = 1'b0;

    do_op("mul_basic", 2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, full_lat, full_ce, 0);
    do_op("mulhu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, full_lat, full_ce, 0);
    do_op("mulh_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, full_lat, full_ce, 0);
    do_op("mulhsu_neg", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, full_lat, full_ce, 0);
    do_op("mulh_mixed", 2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, full_lat, full_ce, 0);
    do_op("mul_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, full_lat, full_ce, 0);
    do_op("mulh_bneg", 2'b01, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, full_lat, full_ce, 0);
    do_op("mulhsu_pos", 2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, full_lat, full_ce, 0);
    do_op("mulh_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, full_lat, full_ce, 0);
    do_op("mulhu_cross", 2'b11, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, full_lat, full_ce, 5);

    // Abort mid-operation with an asynchronous reset pulse in cycle T+3
    @(negedge clock);
    req_valid = 1'b1;
    req_a     = 32'h0000_0007;
    req_b     = 32'h0000_0009;
    req_funct = 2'b00;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    IRSTTOP = 1'b1;
    #1;
    check("arst_req_ready", {31'd0, req_ready}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_dsp_ce", {31'd0, dsp_ce}, 32'd0);
    check("arst_dsp_ab", {dsp_a, dsp_b}, 32'd0);
    check("arst_rsp_data", rsp_data, 32'd0);
    @(negedge clock);
    IRSTTOP = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    check("arst_no_rsp", 32'(seen), 32'd0);
    do_op("mul_after_rst", 2'b00, 32'd3, 32'd5, 32'h0000_000F, full_lat, full_ce, 0);

`ifdef MAC_SEQ_ZERO_SKIP_EN
    do_op("mul_zero", 2'b00, 32'd0, 32'h0000_1234, 32'd0, 1, 0, 0);
`else
    do_op("mul_zero", 2'b00, 32'd0, 32'h0000_1234, 32'd0, full_lat, full_ce, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
